// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin front end for a single shared multi-cycle subtract
// unit. One operation is outstanding at a time. A requester wins in IDLE, its
// operands go to the unit, and the difference comes back to the owner with a
// locally computed borrow. A WAIT timeout turns a missing completion into an
// error response.
//
// Handshake rule for every req/resp channel: a transfer happens on a rising
// clock edge where valid and ready are both high. Valid never depends on
// ready. req_ready is a combinational grant that is only offered in IDLE.
// resp_valid/difference/borrow/error stay stable until the owner's resp_ready.
module sub_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_minuend,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_subtrahend,
   output logic [NUM_REQ-1:0]            o_resp_valid,
   input  logic [NUM_REQ-1:0]            i_resp_ready,
   output logic [DATA_WIDTH-1:0]         o_resp_difference,
   output logic                          o_resp_borrow,
   output logic                          o_resp_error,
   output logic                          o_sub_start,
   output logic [DATA_WIDTH-1:0]         o_sub_minuend,
   output logic [DATA_WIDTH-1:0]         o_sub_subtrahend,
   input  logic [DATA_WIDTH-1:0]         i_sub_difference,
   input  logic                          i_sub_complete,
   output logic [1:0]                    o_state
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t                r_state;
   logic [PTR_W-1:0]      r_rr_ptr;
   logic [PTR_W-1:0]      r_owner;
   logic [DATA_WIDTH-1:0] r_minuend;
   logic [DATA_WIDTH-1:0] r_subtrahend;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_borrow;
   logic                  r_error;
   logic [CNT_W-1:0]      r_count;

   logic                  w_found;
   logic [PTR_W-1:0]      w_winner;
   logic [PTR_W:0]        w_idx;
   logic [DATA_WIDTH-1:0] w_sel_minuend;
   logic [DATA_WIDTH-1:0] w_sel_subtrahend;
   logic [PTR_W-1:0]      w_next_ptr;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
            w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
         end
         if (!w_found && i_req_valid[w_idx[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[PTR_W-1:0];
         end
      end
   end

   assign w_sel_minuend    = i_req_minuend[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
   assign w_sel_subtrahend = i_req_subtrahend[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
   assign w_next_ptr       = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

   // Grant is offered only in IDLE, one-hot to the search winner.
   always_comb begin
      o_req_ready = '0;
      if (r_state == IDLE && w_found) begin
         o_req_ready[w_winner] = 1'b1;
      end
   end

   // Response valid goes only to the owner of the outstanding operation.
   always_comb begin
      o_resp_valid = '0;
      if (r_state == RESPOND) begin
         o_resp_valid[r_owner] = 1'b1;
      end
   end

   assign o_sub_start       = (r_state == ISSUE);
   assign o_sub_minuend     = r_minuend;
   assign o_sub_subtrahend  = r_subtrahend;
   assign o_resp_difference = r_result;
   assign o_resp_borrow     = r_borrow;
   assign o_resp_error      = r_error;
   assign o_state           = r_state;

   // Sequencer: accept, start the unit, wait for completion or timeout, respond.
   // A completion strobe outside WAIT is simply not looked at.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_minuend    <= '0;
         r_subtrahend <= '0;
         r_result     <= '0;
         r_borrow     <= 1'b0;
         r_error      <= 1'b0;
         r_count      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_minuend    <= w_sel_minuend;
                  r_subtrahend <= w_sel_subtrahend;
                  r_owner      <= w_winner;
                  r_borrow     <= (w_sel_minuend < w_sel_subtrahend);
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               r_count <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               // Completion takes priority over a timeout in the same cycle.
               if (i_sub_complete) begin
                  r_result <= i_sub_difference;
                  r_error  <= 1'b0;
                  r_state  <= RESPOND;
               end else if (r_count == CNT_W'(TIMEOUT-1)) begin
                  r_result <= '0;
                  r_borrow <= 1'b0;
                  r_error  <= 1'b1;
                  r_state  <= RESPOND;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            RESPOND: begin
               if (i_resp_ready[r_owner]) begin
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle subtract unit among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the unit's start/complete protocol. It returns each difference, plus a borrow flag, to the owning requester, and bounds every operation with a timeout. It sits between the datapath clients and the single subtract instance.

## Interface
- DATA_WIDTH, 32: operand/result width.
- NUM_REQ, 4: number of requesters (2..16).
- TIMEOUT, 16: max cycles in WAIT before an error response (≥4).
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  requester i has an operation pending.
- req_ready  out  NUM_REQ  one-hot accept; the handshake completes when valid&ready are both high.
- req_minuend  in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_subtrahend  in  NUM_REQ*DATA_WIDTH  same packing.
- resp_valid  out  NUM_REQ  one-hot, to the owning requester.
- resp_ready  in  NUM_REQ  requester i accepts its response.
- resp_difference  out  DATA_WIDTH  (minuend − subtrahend) mod 2^DATA_WIDTH.
- resp_borrow  out  1  minuend < subtrahend (unsigned).
- resp_error  out  1  timeout occurred; difference=0, borrow=0.
- sub_start  out  1  one-cycle start pulse to the subtract unit.
- sub_minuend  out  DATA_WIDTH  operand to the unit; held stable from ISSUE through WAIT.
- sub_subtrahend  out  DATA_WIDTH  operand to the unit; held stable likewise.
- sub_difference  in  DATA_WIDTH  unit result, valid while sub_complete=1.
- sub_complete  in  1  unit result strobe.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Winner = first requester with req_valid, searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally; all other bits are 0.
  - On handshake: register operands, owner index and borrow (minuend<subtrahend), then go to ISSUE.
  - If no req_valid: stay in IDLE with req_ready=0.
- ISSUE: sub_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: the counter increments each cycle.
  - sub_complete=1: capture sub_difference and clear error; go to RESPOND.
  - Counter reaches TIMEOUT−1 without complete: set error, difference=0, borrow=0; go to RESPOND.
  - Complete and timeout in the same cycle: complete wins.
- RESPOND:
  - resp_valid[owner]=1, with difference/borrow/error held stable until resp_ready[owner]=1.
  - On that handshake: rr_ptr=(owner+1) mod NUM_REQ; go to IDLE.
  - resp_ready from non-owners is ignored.
- Only one operation is outstanding at a time. req_ready=0 in every state except IDLE.
- sub_complete outside WAIT, such as a late strobe after a timeout, is ignored and must not corrupt state.
- sub_minuend/sub_subtrahend are driven from the operand registers at all times; they are 0 after reset.
- Arithmetic: resp_difference is taken from the unit and is not recomputed. resp_borrow is computed locally on the registered operands.
- rr_ptr advances only on a completed response, including error responses.

## Timing
- Reset (async assert, synchronous release): state=IDLE, rr_ptr=0, operand/result/owner registers=0.
  - Outputs after reset: req_ready=0 when no valid, resp_valid=0, resp_difference=0, resp_borrow=0, resp_error=0, sub_start=0.
- Reset mid-operation: the operation is abandoned with no response issued, and rr_ptr returns to 0.
- Latency with a unit that asserts complete 2 cycles after sampling start:
  - Handshake in cycle 0, sub_start in cycle 1, sub_complete sampled in cycle 3.
  - resp_valid in cycle 4.
  - If resp_ready is already high, the next request can be accepted in cycle 5.
- Throughput: one operation per (unit latency + 3) cycles, minimum.
- Timeout: with no complete, resp_valid with resp_error=1 is asserted in cycle TIMEOUT+2 after the handshake.
- req_valid may be asserted or dropped freely while req_ready=0; operands are sampled only in the handshake cycle.

## Test plan
- Single request: requester 0, 100−30 → req_ready[0] in cycle 0, sub_start in cycle 1, resp_valid[0] in cycle 4 with difference 70, borrow 0, error 0.
- Underflow: requester 2, 5−7 (DATA_WIDTH=32) → difference 0xFFFF_FFFE, borrow 1.
- Fairness: all 4 req_valid held high with resp_ready tied high → grant order 0,1,2,3,0 and no requester starved. Then with requesters 1 and 3 only, after serving 1 the next grant is 3.
- Backpressure: hold resp_ready[owner]=0 for 10 cycles → resp_valid and result stay stable, no new req_ready, and sub_start is not reasserted. A resp_ready pulse from a non-owner has no effect.
- Timeout: unit never completes, TIMEOUT=16 → error response with difference 0 in cycle 18. A late sub_complete in IDLE is ignored, and the next request completes correctly.
- Reset mid-WAIT: assert reset during WAIT → all outputs return to their reset values immediately, no response is issued, and the first grant after release goes to the lowest-index valid requester.
